// File: rtl/lsu_mem_ctrl.sv
// Load/store front end for a 2^MEM_AW x 32 synchronous-read data memory macro.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module lsu_mem_ctrl #(
    parameter int          MEM_AW   = 10,
    parameter logic [31:0] MEM_BASE = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic [31:0]       mem_bwen,
    output logic [MEM_AW-1:0] mem_a,
    output logic [31:0]       mem_d,
    input  logic [31:0]       mem_q
);

    typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, RSP = 2'd2} state_t;

    state_t      state;
    logic [1:0]  lat_lo;
    logic [1:0]  lat_size;
    logic        lat_uns;
    logic        accept;
    logic        range_err;
    logic        size_err;
    logic        req_err;
    logic [1:0]  eff_lo;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign req_ready = (state == IDLE) && !RST;
    assign accept    = req_valid && req_ready;
    assign range_err = req_addr[31:MEM_AW+2] != MEM_BASE[31:MEM_AW+2];
    assign size_err  = req_size == 2'b11;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign req_err  = range_err || size_err || misalign;
`else
    assign req_err  = range_err || size_err;
`endif

    // Low address bits with the size's alignment forced; harmless when misalignment traps.
    always_comb begin
        case (req_size)
            2'b01:   eff_lo = {req_addr[1], 1'b0};
            2'b10:   eff_lo = 2'b00;
            default: eff_lo = req_addr[1:0];
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        mem_cen  = 1'b0;
        mem_wen  = 1'b1;
        mem_bwen = '0;
        mem_a    = '0;
        mem_d    = '0;
        if (accept && !req_err) begin
            mem_cen = 1'b1;
            mem_wen = !req_we;
            mem_a   = req_addr[MEM_AW+1:2];
            if (req_we) begin
                case (req_size)
                    2'b00: begin
                        mem_d    = {4{req_wdata[7:0]}};
                        mem_bwen = 32'h0000_00FF << {eff_lo, 3'b000};
                    end
                    2'b01: begin
                        mem_d    = {2{req_wdata[15:0]}};
                        mem_bwen = 32'h0000_FFFF << {eff_lo[1], 4'b0000};
                    end
                    default: begin
                        mem_d    = req_wdata;
                        mem_bwen = 32'hFFFF_FFFF;
                    end
                endcase
            end
        end
    end

    // Latched low bits are already size-aligned, so one byte-granular shift serves all sizes.
    always_comb begin
        shifted = mem_q >> {lat_lo, 3'b000};
        case (lat_size)
            2'b00:   load_data = lat_uns ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = lat_uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments; the reset clears all of it.
        if (RST) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_lo    <= '0;
            lat_size  <= '0;
            lat_uns   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_lo   <= eff_lo;
                        lat_size <= req_size;
                        lat_uns  <= req_unsigned;
                        if (req_err || req_we) begin
                            state     <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_err   <= req_err;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    state     <= RSP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= load_data;
                    rsp_err   <= 1'b0;
                end
                RSP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
